// File: rtl/esc_pkg.sv
// Shared ESC definitions: PID sequencer state encoding, error clamp limits,
// accumulator width and the signed 8-bit saturation helper.
package esc_pkg;

  typedef enum logic [2:0] {
    IDLE, ERR, MUL_P, MUL_I, MUL_D, OUT
  } pid_seq_state_t;

  localparam int ERR_MIN   = -128;
  localparam int ERR_MAX   = 127;
  localparam int PID_ACC_W = 18;

  // Saturate a 10-bit signed intermediate to the signed 8-bit error range.
  function automatic logic signed [7:0] sat8(input logic signed [9:0] v);
    if (v < 10'(ERR_MIN))      return 8'sh80;
    else if (v > 10'(ERR_MAX)) return 8'sh7F;
    else                       return v[7:0];
  endfunction

endpackage

// File: rtl/pid_mac_sequencer_mul.sv
// Shared PID term multiplier: signed 8-bit operand times unsigned 8-bit gain.
module pid_term_mul (
  input  logic signed [7:0]  a_i,
  input  logic        [7:0]  b_i,
  output logic signed [16:0] p_o
);

  // Zero-extend the gain so the product is a plain signed multiply.
  assign p_o = 17'(a_i * $signed({1'b0, b_i}));

endmodule

// File: rtl/pid_mac_sequencer.sv
// Multi-cycle PID speed-loop controller sharing one 8x8 multiplier across P/I/D.
// Define PID_SEQ_DERIV_EN to include the derivative term (latency 5, else 4).
module pid_mac_sequencer
  import esc_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] DUTY_MAX   = 16'd255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      sample_valid,
  input  logic [DATA_WIDTH-1:0]     period_meas,
  input  logic [DATA_WIDTH/2-1:0]   period_ref,
  input  logic [DATA_WIDTH/2-1:0]   kp,
  input  logic [DATA_WIDTH/2-1:0]   ki,
  input  logic [DATA_WIDTH/2-1:0]   kd,
  output logic                      busy,
  output logic [DATA_WIDTH-1:0]     duty,
  output logic                      duty_valid,
  output logic                      overrun
);

  pid_seq_state_t state_q, state_d;
  logic [DATA_WIDTH-1:0]        meas_q, meas_d;
  logic [7:0]                   ref_q, ref_d, kp_q, kp_d, ki_q, ki_d;
  logic signed [7:0]            err_q, err_d, integ_q, integ_d, prev_q, prev_d;
  logic signed [PID_ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_WIDTH-1:0]        duty_q, duty_d;
  logic                         dv_q, dv_d, ov_q, ov_d;

  logic [7:0]                   meas8;
  logic signed [9:0]            err_w, integ_w, deriv_w;
  logic signed [7:0]            err_c, mul_a;
  logic [7:0]                   mul_b;
  logic signed [16:0]           prod;
  logic signed [PID_ACC_W-1:0]  acc_add;

`ifdef PID_SEQ_DERIV_EN
  logic [7:0]        kd_q, kd_d;
  logic signed [7:0] deriv_q, deriv_d;
`else
  logic unused_kd;
  assign unused_kd = ^kd;
`endif

  assign meas8   = (|meas_q[DATA_WIDTH-1:8]) ? 8'hFF : meas_q[7:0];
  assign err_w   = $signed({2'b00, ref_q}) - $signed({2'b00, meas8});
  assign err_c   = sat8(err_w);
  assign integ_w = {{2{integ_q[7]}}, integ_q} + {{2{err_c[7]}}, err_c};
  assign deriv_w = {{2{err_c[7]}}, err_c} - {{2{prev_q[7]}}, prev_q};

  // Operand mux: the FSM state selects which latched term/gain pair is multiplied.
  always_comb begin
    mul_a = err_q;
    mul_b = kp_q;
    case (state_q)
      MUL_I: begin mul_a = integ_q; mul_b = ki_q; end
`ifdef PID_SEQ_DERIV_EN
      MUL_D: begin mul_a = deriv_q; mul_b = kd_q; end
`endif
      default: ;
    endcase
  end

  pid_term_mul u_mul (.a_i(mul_a), .b_i(mul_b), .p_o(prod));

  assign acc_add = acc_q + {prod[16], prod};

  always_comb begin
    state_d = state_q;
    meas_d  = meas_q;
    ref_d   = ref_q;
    kp_d    = kp_q;
    ki_d    = ki_q;
    err_d   = err_q;
    integ_d = integ_q;
    prev_d  = prev_q;
    acc_d   = acc_q;
    duty_d  = duty_q;
    dv_d    = 1'b0;
    ov_d    = enable && sample_valid && (state_q != IDLE);
`ifdef PID_SEQ_DERIV_EN
    kd_d    = kd_q;
    deriv_d = deriv_q;
`endif
    if (!enable) begin
      state_d = IDLE;
      integ_d = '0;
      prev_d  = '0;
      acc_d   = '0;
      duty_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (sample_valid) begin
          meas_d  = period_meas;
          ref_d   = period_ref;
          kp_d    = kp;
          ki_d    = ki;
`ifdef PID_SEQ_DERIV_EN
          kd_d    = kd;
`endif
          acc_d   = '0;
          state_d = ERR;
        end
        ERR: begin
          err_d   = err_c;
          integ_d = sat8(integ_w);
          prev_d  = err_c;
`ifdef PID_SEQ_DERIV_EN
          deriv_d = sat8(deriv_w);
`endif
          state_d = MUL_P;
        end
        MUL_P: begin
          acc_d   = acc_add;
          state_d = MUL_I;
        end
        MUL_I: begin
          acc_d   = acc_add;
`ifdef PID_SEQ_DERIV_EN
          state_d = MUL_D;
`else
          state_d = OUT;
`endif
        end
        MUL_D: begin
          acc_d   = acc_add;
          state_d = OUT;
        end
        OUT: begin
          if (acc_q[PID_ACC_W-1])
            duty_d = '0;
          else if (acc_q[PID_ACC_W-2:0] > {1'b0, DUTY_MAX})
            duty_d = DUTY_MAX;
          else
            duty_d = acc_q[DATA_WIDTH-1:0];
          dv_d    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      meas_q  <= '0;
      ref_q   <= '0;
      kp_q    <= '0;
      ki_q    <= '0;
      err_q   <= '0;
      integ_q <= '0;
      prev_q  <= '0;
      acc_q   <= '0;
      duty_q  <= '0;
      dv_q    <= 1'b0;
      ov_q    <= 1'b0;
`ifdef PID_SEQ_DERIV_EN
      kd_q    <= '0;
      deriv_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      meas_q  <= meas_d;
      ref_q   <= ref_d;
      kp_q    <= kp_d;
      ki_q    <= ki_d;
      err_q   <= err_d;
      integ_q <= integ_d;
      prev_q  <= prev_d;
      acc_q   <= acc_d;
      duty_q  <= duty_d;
      dv_q    <= dv_d;
      ov_q    <= ov_d;
`ifdef PID_SEQ_DERIV_EN
      kd_q    <= kd_d;
      deriv_q <= deriv_d;
`endif
    end
  end

  assign busy       = (state_q != IDLE);
  assign duty       = duty_q;
  assign duty_valid = dv_q;
  assign overrun    = ov_q;

endmodule
